// File: rtl/fu_sequencer.sv
// fu_sequencer: multi-pass controller for the function unit and register file.
// Optional FU_ZERO_EXIT_EN: leave a repeat sequence early once the unit reports zero.
module fu_sequencer #(
  parameter int N    = 4,
  parameter int RA_W = 3,
  parameter int IW   = 5 + 3*RA_W + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [IW-1:0]   instr,
  output logic [4:0]      fs,
  output logic [RA_W-1:0] aa,
  output logic [RA_W-1:0] ba,
  output logic [RA_W-1:0] da,
  output logic            rf_we,
  input  logic [3:0]      flags_in,
  output logic [3:0]      flags_q,
  output logic            busy,
  output logic            done
);

  if (N < 1 || IW != 5 + 3*RA_W + 2) begin : g_bad_params
    $error("fu_sequencer: instruction width must equal 5 + 3*RA_W + 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FsLsb = IW - 5;
  localparam int DaLsb = 2 + 2*RA_W;
  localparam int AaLsb = 2 + RA_W;
  localparam int BaLsb = 2;

  state_e     state_q;
  logic [1:0] cnt_q;
  logic       lastPass;

  // The zero-exit only shortens the sequence; the current pass still writes.
`ifdef FU_ZERO_EXIT_EN
  assign lastPass = (cnt_q == 2'd0) || flags_in[1];
`else
  assign lastPass = (cnt_q == 2'd0);
`endif

  // fs/aa/ba/da double as the instruction register; in IDLE and DONE they keep
  // their last values, so rf_we alone qualifies a register-file write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      fs          <= 5'd0;
      aa          <= '0;
      ba          <= '0;
      da          <= '0;
      rf_we       <= 1'b0;
      flags_q     <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            fs          <= instr[FsLsb +: 5];
            da          <= instr[DaLsb +: RA_W];
            aa          <= instr[AaLsb +: RA_W];
            ba          <= instr[BaLsb +: RA_W];
            cnt_q       <= instr[1:0];
            rf_we       <= 1'b1;
            busy        <= 1'b1;
            instr_ready <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          flags_q <= flags_in;
          if (lastPass) begin
            rf_we   <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            // Later passes operate on the value just written to DA.
            cnt_q <= cnt_q - 2'd1;
            aa    <= da;
            ba    <= da;
          end
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          rf_we       <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
